multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset as elsewhere in the codebase.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 Instr  in  20  instruction-register bits [31:12]: cond=[31:28], op=[27:26], funct=[25:20], Rd=[15:12]; stable from DECODE until the next FETCH.
REQ-005 ALUFlags  in  4  live ALU flags {N,Z,C,V} for the current cycle's ALU operation.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables for PC, instruction register, register file and data memory.
REQ-007 AdrSrc  out  1  memory address select (0=PC, 1=ALUOut); ALUSrcA  out  1  ALU A select (0=register, 1=PC).
REQ-008 ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  ALU B select (00 reg, 01 extimm, 10 const 4), result select (00 ALUOut, 01 Data, 10 ALUResult), immediate format, register-address select.
REQ-009 ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR.
REQ-010 State  out  4  current FSM state encoding, for debug and verification only.

Function
REQ-011 The block SHALL implement a registered FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 SHALL go to FETCH on the next cycle.
REQ-012 Transitions: FETCH->DECODE; DECODE -> MEMADR (op=01), EXECR (op=00, funct[5]=0), EXECI (op=00, funct[5]=1), BRANCH (op=10), FETCH (op=11).
REQ-013 Transitions (cont.): MEMADR->MEMRD if funct[0]=1, else MEMWR; MEMRD->MEMWB->FETCH; MEMWR->FETCH; EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
REQ-014 Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, op=11 2 (NOP).
REQ-015 Moore controls per state (unlisted outputs 0):
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU=ADD.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU=ADD.
- MEMADR: ALUSrcB=01, ALU=ADD. MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=CondEx. MEMWR: AdrSrc=1, MemWrite=CondEx.
- EXECR: ALUSrcB=00, ALU from decoder. EXECI: ALUSrcB=01, ALU from decoder. ALUWB: ResultSrc=00, RegWrite=CondEx & NoWrite=0.
- BRANCH: ALUSrcB=01, ResultSrc=10, ALU=ADD, PCWrite=CondEx.
REQ-016 The ALU decoder SHALL map funct[4:1] as follows in EXECR/EXECI: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 SUB with NoWrite=1 (CMP). Any other value SHALL produce ADD with NoWrite=1 and no flag update.
REQ-017 ImmSrc and RegSrc SHALL be combinational in every state: ImmSrc=op; RegSrc[0]=(op==10); RegSrc[1]=(op==01).
REQ-018 A 4-bit Flags register SHALL hold {N,Z,C,V}. At the end of EXECR/EXECI, when funct[0]=1, CondEx=1 and the cmd is legal:
- N and Z SHALL be loaded from ALUFlags.
- C and V SHALL be loaded only for ADD/SUB/CMP.
Flags SHALL hold their value in all other cycles.
REQ-019 CondEx SHALL be combinational from cond and the registered Flags, never from live ALUFlags:
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
- HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
- AL 1; cond 1111 SHALL give 0.
REQ-020 A failed condition SHALL still traverse the full state sequence with all architectural writes (RegWrite, MemWrite, branch PCWrite, Flags) suppressed. The FETCH PCWrite is unconditional.
REQ-021 Because a flag update in EXECR/EXECI commits at the clock edge, a later instruction SHALL observe the new flags in its own DECODE/EXEC states.

Reset
REQ-022 While reset=1 at a clock edge, State SHALL become FETCH and Flags SHALL become 0000. Reset SHALL take priority in any state, including mid-instruction.
REQ-023 In the first cycle after reset deasserts, the outputs SHALL be the FETCH values (IRWrite=1, PCWrite=1, all other enables 0). No partial write from the aborted instruction SHALL occur after reset.

Verification
REQ-024 Reset, then Instr=E280_0_xxx (ADDI, AL) -> States 0,1,7,8,0; RegWrite=1 only in ALUWB; ALUControl=0000 in EXECI.
REQ-025 LDR (op=01, funct[0]=1, AL) -> States 0,1,2,3,4; AdrSrc=1 in MEMRD; RegWrite=1 with ResultSrc=01 in MEMWB. STR (funct[0]=0) -> 0,1,2,5 with MemWrite=1 only in MEMWR.
REQ-026 CMP (cmd 1010, S=1) with ALUFlags=0100 in EXECR -> Flags=0100 and RegWrite=0 in ALUWB. A following BEQ (cond 0000, op=10) -> PCWrite=1 in BRANCH. A following BNE -> PCWrite=0 in BRANCH.
REQ-027 Flags=0000 and ADDS-EQ (cond 0000, S=1) with ALUFlags=1111 -> full 0,1,6,8 sequence with RegWrite=0 and Flags still 0000.
REQ-028 Assert reset during MEMWR -> next State=0, MemWrite=0, Flags=0000. Separately, op=11 -> States 0,1,0 with no writes except the FETCH PCWrite/IRWrite.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath:
// instruction/flag inputs to the controller and the per-cycle control outputs.
interface multicycle_control_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  ALUControl;
  logic [3:0]  State;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset controller: Moore FSM, ALU decoder, condition check
// against a registered NZCV flags register.
module multicycle_control (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.slave   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;
  logic [3:0]  w_flags_next;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_cmd;
  logic [3:0]  w_alu_dec;
  logic        w_nowrite;
  logic        w_legal;
  logic        w_arith;
  logic        w_condex;
  logic        w_unused_instr;

  assign w_cond         = bus.Instr[19:16];
  assign w_op           = bus.Instr[15:14];
  assign w_funct        = bus.Instr[13:8];
  assign w_cmd          = w_funct[4:1];
  assign w_unused_instr = ^bus.Instr[7:0];

  always_comb begin
    w_alu_dec = 4'b0000;
    w_nowrite = 1'b1;
    w_legal   = 1'b0;
    w_arith   = 1'b0;
    case (w_cmd)
      4'b0100: begin w_alu_dec = 4'b0000; w_nowrite = 1'b0; w_legal = 1'b1; w_arith = 1'b1; end
      4'b0010: begin w_alu_dec = 4'b0001; w_nowrite = 1'b0; w_legal = 1'b1; w_arith = 1'b1; end
      4'b0000: begin w_alu_dec = 4'b0010; w_nowrite = 1'b0; w_legal = 1'b1; end
      4'b1100: begin w_alu_dec = 4'b0011; w_nowrite = 1'b0; w_legal = 1'b1; end
      4'b1010: begin w_alu_dec = 4'b0001; w_nowrite = 1'b1; w_legal = 1'b1; w_arith = 1'b1; end
      default: ;
    endcase
  end

  // Condition is evaluated against committed flags only, never live ALUFlags.
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'b0000: w_condex = r_flags[2];
      4'b0001: w_condex = ~r_flags[2];
      4'b0010: w_condex = r_flags[1];
      4'b0011: w_condex = ~r_flags[1];
      4'b0100: w_condex = r_flags[3];
      4'b0101: w_condex = ~r_flags[3];
      4'b0110: w_condex = r_flags[0];
      4'b0111: w_condex = ~r_flags[0];
      4'b1000: w_condex = r_flags[1] & ~r_flags[2];
      4'b1001: w_condex = ~r_flags[1] | r_flags[2];
      4'b1010: w_condex = (r_flags[3] == r_flags[0]);
      4'b1011: w_condex = (r_flags[3] != r_flags[0]);
      4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  always_comb begin
    w_flags_next = r_flags;
    if (((r_state == S_EXECR) || (r_state == S_EXECI)) && w_funct[0] && w_condex && w_legal) begin
      w_flags_next[3:2] = bus.ALUFlags[3:2];
      if (w_arith)
        w_flags_next[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      r_flags <= w_flags_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = 4'b0000;
    case (r_state)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_MEMADR: bus.ALUSrcB = 2'b01;
      S_MEMRD:  bus.AdrSrc  = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = w_condex;
      end
      S_MEMWR: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = w_condex;
      end
      S_EXECR:  bus.ALUControl = w_alu_dec;
      S_EXECI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = w_alu_dec;
      end
      S_ALUWB:  bus.RegWrite = w_condex & ~w_nowrite;
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = w_condex;
      end
      default: ;
    endcase
  end

  assign bus.ImmSrc = w_op;
  assign bus.RegSrc = {(w_op == 2'b01), (w_op == 2'b10)};
  assign bus.State  = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction reference model
// pushes expected per-cycle control words; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic clk;
  logic reset;
  logic mon_en;
  int unsigned errors;
  int unsigned checks;
  logic [3:0] m_flags;
  logic [25:0] exp_q[$];

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] fl);
    logic n, z, c, v;
    {n, z, c, v} = fl;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // cmd -> {legal, arith, nowrite, alu[3:0]}
  function automatic logic [6:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return {3'b110, 4'd0};
      4'b0010: return {3'b110, 4'd1};
      4'b0000: return {3'b100, 4'd2};
      4'b1100: return {3'b100, 4'd3};
      4'b1010: return {3'b111, 4'd1};
      default: return {3'b001, 4'd0};
    endcase
  endfunction

  function automatic logic [25:0] mk(input logic [3:0] st, input logic [19:0] ins, input logic [3:0] fl);
    logic pcw, irw, rw, mw, adr, sa;
    logic [1:0] sb, res, op;
    logic [3:0] alu;
    logic ce;
    logic [6:0] d;
    op = ins[15:14];
    ce = cond_ok(ins[19:16], fl);
    d  = alu_of(ins[12:9]);
    {pcw, irw, rw, mw, adr, sa} = '0;
    sb = 2'd0; res = 2'd0; alu = 4'd0;
    case (st)
      4'd0: begin pcw = 1; irw = 1; sa = 1; sb = 2; res = 2; end
      4'd1: begin sa = 1; sb = 2; res = 2; end
      4'd2: sb = 1;
      4'd3: adr = 1;
      4'd4: begin res = 1; rw = ce; end
      4'd5: begin adr = 1; mw = ce; end
      4'd6: alu = d[3:0];
      4'd7: begin sb = 1; alu = d[3:0]; end
      4'd8: rw = ce && !d[4];
      4'd9: begin sb = 1; res = 2; pcw = ce; end
      default: ;
    endcase
    return {st, pcw, irw, rw, mw, adr, sa, sb, res, op, (op == 2'b01), (op == 2'b10), alu, fl};
  endfunction

  function automatic logic [3:0] upd(input logic [19:0] ins, input logic [3:0] fl, input logic [3:0] af);
    logic [6:0] d;
    logic [3:0] r;
    d = alu_of(ins[12:9]);
    r = fl;
    if (ins[8] && cond_ok(ins[19:16], fl) && d[6]) begin
      r[3:2] = af[3:2];
      if (d[5]) r[1:0] = af[1:0];
    end
    return r;
  endfunction

  // abort_k != 0: reset is asserted during the abort_k-th cycle of this instruction
  task automatic issue(input logic [19:0] ins, input logic [3:0] af, input int unsigned abort_k);
    logic [3:0] seq[$];
    logic [3:0] fl;
    int unsigned n, k;
    seq.push_back(4'd0);
    seq.push_back(4'd1);
    case (ins[15:14])
      2'b00: begin seq.push_back(ins[13] ? 4'd7 : 4'd6); seq.push_back(4'd8); end
      2'b01: begin
        seq.push_back(4'd2);
        if (ins[8]) begin seq.push_back(4'd3); seq.push_back(4'd4); end
        else seq.push_back(4'd5);
      end
      2'b10: seq.push_back(4'd9);
      default: ;
    endcase
    n = seq.size();
    k = (abort_k == 0 || abort_k > n) ? n : abort_k;
    fl = m_flags;
    bus.Instr = ins;
    bus.ALUFlags = af;
    for (int unsigned i = 0; i < k; i++) begin
      exp_q.push_back(mk(seq[i], ins, fl));
      if (seq[i] == 4'd6 || seq[i] == 4'd7) fl = upd(ins, fl, af);
    end
    repeat (k - 1) begin @(posedge clk); #1; end
    if (abort_k != 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_flags = 4'd0;
    end else begin
      @(posedge clk); #1;
      m_flags = fl;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [25:0] act, e;
      act = {bus.State, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
             bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
             bus.RegSrc, bus.ALUControl, dut.r_flags};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: output cycle with no expected entry, got %h", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e)
          $display("FAIL cycle t=%0t state/ctl/flags: got %h expected %h (state got %0d exp %0d)",
                   $time, act, e, act[25:22], e[25:22]);
        if (act !== e) errors++;
      end
    end
  end

  initial begin
    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic [19:0] ins;
    errors = 0;
    checks = 0;
    mon_en = 1'b0;
    m_flags = 4'd0;
    reset = 1'b1;
    bus.Instr = 20'h0;
    bus.ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    issue(20'hE2800, 4'h0, 0);   // ADDI AL
    issue(20'hE5900, 4'h0, 0);   // LDR
    issue(20'hE5800, 4'h0, 0);   // STR
    issue(20'hE1500, 4'h4, 0);   // CMP -> Z
    issue(20'h0A000, 4'h0, 0);   // BEQ taken
    issue(20'h1A000, 4'h0, 0);   // BNE not taken
    issue(20'hE5800, 4'h0, 4);   // STR, reset during MEMWR
    issue(20'h00900, 4'hF, 0);   // ADDS-EQ with Z=0
    issue(20'hEC000, 4'h0, 0);   // op=11 NOP

    for (int unsigned t = 0; t < 300; t++) begin
      cond = ($urandom_range(0, 7) < 3) ? 4'hE : 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        4: cmd = 4'b1010;
        default: cmd = 4'($urandom);
      endcase
      funct = {1'($urandom), cmd, 1'($urandom)};
      ins = {cond, op, funct, 8'($urandom)};
      issue(ins, 4'($urandom), ($urandom_range(0, 15) == 0) ? $urandom_range(1, 5) : 0);
    end

    for (int unsigned w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
